match_run_monitor: RTL
======================

MATCH_RUN_MONITOR -- requirements
Module: match_run_monitor

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately.
- en  in  1  sample strobe; all state advances only on a clk edge with en=1.
- w  in  1  serial bit, the same bit fed to the upstream run detector.
- z  in  1  upstream detector output; high while the last 4+ bits of w are equal.
- clr  in  1  synchronous clear of the statistics (qualified by en).
- match_pulse  out  1  one-en-cycle pulse on each new match event.
- zero_evt  out  4  count of all-zero match events.
- one_evt  out  4  count of all-one match events.
- evt_bcd  out  8  total match events as 2-digit BCD: [7:4] tens, [3:0] units.
- ovf  out  1  sticky flag; total count wrapped past 99.
- run_len  out  4  length of the current run of equal w samples.
- max_run  out  4  longest run_len since reset or clr.
- hex0  out  7  active-low 7-segment digit for evt_bcd[3:0]; segment order g..a = [6:0].
- hex1  out  7  active-low 7-segment digit for evt_bcd[7:4]; same segment order.

Function
REQ-002 Timing: all outputs except hex0/hex1 SHALL be registered and update on the clk edge that samples en=1; hex0/hex1 SHALL be combinational decodes of the registered evt_bcd.
REQ-003 prev_w register: loads w on every en edge; reset value 0.
REQ-004 prev_w is the polarity of a match; z sampled on the same edge reflects the detector state built from prev_w.
REQ-005 run_len, first en edge after reset: 1.
REQ-006 run_len, later en edges: increments when w==prev_w, saturating at 15; otherwise loads 1.
REQ-007 max_run: on each en edge, loads the larger of its current value and the next run_len.
REQ-008 The FSM SHALL have three states: IDLE, RUN0, RUN1; reset state IDLE.
REQ-009 FSM transitions on an en edge:
- IDLE, z=1: go to RUN0 if prev_w=0, else RUN1; this is a match event.
- IDLE, z=0: stay in IDLE.
- RUN0, z=0: go to IDLE. RUN1, z=0: go to IDLE.
- RUN0 with z=1 and prev_w=1: go to RUN1; this is a new match event.
- RUN1 with z=1 and prev_w=0: go to RUN0; this is a new match event.
- Otherwise: hold state.
REQ-010 match_pulse SHALL be 1 for exactly the en cycle following a match event edge.
REQ-011 match_pulse SHALL be 0 after any edge with en=0, and 0 at reset.
REQ-012 On a match event, zero_evt (RUN0 entry) or one_evt (RUN1 entry) SHALL increment, saturating at 15.
REQ-013 On a match event, evt_bcd SHALL increment in BCD: units 9→0 with tens carry; 99→00 wraps and sets ovf.
REQ-014 ovf SHALL stay 1 until reset or clr.
REQ-015 clr=1 with en=1 SHALL clear zero_evt, one_evt, evt_bcd, ovf and max_run to 0 on that edge.
REQ-016 clr SHALL NOT affect the FSM, prev_w, run_len or match_pulse.
REQ-017 clr coincident with a match event: clr wins, so counters read 0 and the event is not counted; match_pulse still asserts and the FSM still transitions.
REQ-018 en=0 SHALL freeze all registers, regardless of clr, w or z.
REQ-019 hex decode: digit values 0-9 map to standard active-low patterns (0 = 1000000); codes 10-15 display all-off (1111111).

Reset
REQ-020 reset=0 SHALL asynchronously force these reset values:
- FSM=IDLE, prev_w=0, run_len=0, max_run=0
- zero_evt=0, one_evt=0, evt_bcd=00, ovf=0, match_pulse=0
- hex0=hex1=1000000
REQ-021 Reset asserted mid-run SHALL discard the run; after release, the first en edge behaves as the first edge after reset (REQ-005).
REQ-022 Reset deassertion SHALL be taken synchronously to clk; the first edge after release is a normal en-qualified edge.

Verification
REQ-023 Reset then w=0 for 6 en edges, detector modelled -> z rises after 4th edge.
- Required: one match_pulse, zero_evt=1, evt_bcd=01, run_len=6, max_run=6.
REQ-024 w=1,1,1,1 then 0, z modelled -> RUN1 entered once; one_evt=1.
- After the 0: FSM returns to IDLE when z falls; run_len=1; max_run holds 4.
REQ-025 Force z held high while prev_w toggles -> RUN0→RUN1 counts a second event.
- Required: two match_pulses, one each in zero_evt and one_evt.
REQ-026 Drive 100 match events -> evt_bcd=00, ovf=1, hex0=hex1=1000000.
- Then clr with en=1: ovf=0, max_run=0.
REQ-027 clr coincident with a match event -> match_pulse=1, evt_bcd=00, FSM in RUNx.
REQ-028 Assert reset mid-run with run_len=7 and evt_bcd=12 -> all outputs reach reset values without a clk edge.
- Then en=0 for 3 edges: no change; the next en edge gives run_len=1.

Source files
------------

// File: rtl/match_run_monitor.sv
// Tracks match events from an upstream equal-run detector, keeping BCD/polarity event statistics and run lengths.
// All outputs registered on en-qualified edges (hex0/hex1 decoded combinationally); no backpressure, en is the only stall.
module match_run_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       w,
  input  logic       z,
  input  logic       clr,
  output logic       match_pulse,
  output logic [3:0] zero_evt,
  output logic [3:0] one_evt,
  output logic [7:0] evt_bcd,
  output logic       ovf,
  output logic [3:0] run_len,
  output logic [3:0] max_run,
  output logic [6:0] hex0,
  output logic [6:0] hex1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN0 = 2'd1,
    RUN1 = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       prev_w;
  logic       evt;
  logic       evt_zero;
  logic       evt_one;
  logic [3:0] run_len_nxt;
  logic [3:0] max_run_nxt;
  logic [7:0] bcd_nxt;
  logic       bcd_wrap;

  // z reflects history up to prev_w, so prev_w gives the polarity of the run z reports.
  always_comb begin
    state_nxt = state;
    evt       = 1'b0;
    case (state)
      IDLE: begin
        if (z) begin
          state_nxt = prev_w ? RUN1 : RUN0;
          evt       = 1'b1;
        end
      end
      RUN0: begin
        if (!z) begin
          state_nxt = IDLE;
        end else if (prev_w) begin
          state_nxt = RUN1;
          evt       = 1'b1;
        end
      end
      RUN1: begin
        if (!z) begin
          state_nxt = IDLE;
        end else if (!prev_w) begin
          state_nxt = RUN0;
          evt       = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign evt_zero = evt && (state_nxt == RUN0);
  assign evt_one  = evt && (state_nxt == RUN1);

  // run_len is only ever 0 straight out of reset, which marks the first sample.
  always_comb begin
    run_len_nxt = 4'd1;
    if ((run_len != 4'd0) && (w == prev_w)) begin
      run_len_nxt = (run_len == 4'd15) ? 4'd15 : run_len + 4'd1;
    end
  end

  always_comb begin
    max_run_nxt = max_run;
    if (clr) begin
      max_run_nxt = 4'd0;
    end else if (run_len_nxt > max_run) begin
      max_run_nxt = run_len_nxt;
    end
  end

  always_comb begin
    bcd_nxt  = evt_bcd;
    bcd_wrap = 1'b0;
    if (evt_bcd[3:0] == 4'd9) begin
      bcd_nxt[3:0] = 4'd0;
      if (evt_bcd[7:4] == 4'd9) begin
        bcd_nxt[7:4] = 4'd0;
        bcd_wrap     = 1'b1;
      end else begin
        bcd_nxt[7:4] = evt_bcd[7:4] + 4'd1;
      end
    end else begin
      bcd_nxt[3:0] = evt_bcd[3:0] + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      prev_w  <= 1'b0;
      run_len <= 4'd0;
    end else if (en) begin
      state   <= state_nxt;
      prev_w  <= w;
      run_len <= run_len_nxt;
    end
  end

  // Unlike the other registers, the pulse drops on any edge without en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= en & evt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_evt <= 4'd0;
      one_evt  <= 4'd0;
      evt_bcd  <= 8'h00;
      ovf      <= 1'b0;
      max_run  <= 4'd0;
    end else if (en) begin
      max_run <= max_run_nxt;
      if (clr) begin
        zero_evt <= 4'd0;
        one_evt  <= 4'd0;
        evt_bcd  <= 8'h00;
        ovf      <= 1'b0;
      end else if (evt) begin
        if (evt_zero && (zero_evt != 4'd15)) begin
          zero_evt <= zero_evt + 4'd1;
        end
        if (evt_one && (one_evt != 4'd15)) begin
          one_evt <= one_evt + 4'd1;
        end
        evt_bcd <= bcd_nxt;
        if (bcd_wrap) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  // Active-low segments, bit order g..a; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign hex0 = seg7(evt_bcd[3:0]);
  assign hex1 = seg7(evt_bcd[7:4]);

endmodule
